calc_multiport_engine: RTL

- Parametrised successor to the single-channel calculator.
- NUM_PORTS independent request channels share one registered ALU through a round-robin arbiter.
- Each channel uses the two-cycle request protocol: command with operand 1, then operand 2 on the next cycle.
- Each channel returns a one-cycle response code with result data.
- Adds subtract, shifts, error responses and contention handling, none of which the single-channel adder provides.

---
 rtl/calc_multiport_engine_if.sv | 41 ++++
 rtl/calc_multiport_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_multiport_engine_if.sv
// Bus bundle for calc_multiport_engine.
//
// Carries all per-port request/response signals as flat packed vectors.
// Port p owns cmd_in[4p+3:4p], data_in[WIDTH*p +: WIDTH], out_resp[2p+1:2p],
// out_data[WIDTH*p +: WIDTH] and busy[p].
//
//   cmd_in    requester -> engine  4-bit command per port
//   data_in   requester -> engine  operand per port (op1 with cmd, op2 one cycle later)
//   out_resp  engine -> requester  2-bit response code, valid for one cycle
//   out_data  engine -> requester  result, non-zero only alongside a success code
//   busy      engine -> requester  port has a request in flight
//
// master: the requester side; slave: the engine side.
interface calc_multiport_engine_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_PORTS = 4
);

  logic [NUM_PORTS*4-1:0]     cmd_in;
  logic [NUM_PORTS*WIDTH-1:0] data_in;
  logic [NUM_PORTS*2-1:0]     out_resp;
  logic [NUM_PORTS*WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]       busy;

  modport master (
    output cmd_in,
    output data_in,
    input  out_resp,
    input  out_data,
    input  busy
  );

  modport slave (
    input  cmd_in,
    input  data_in,
    output out_resp,
    output out_data,
    output busy
  );

endinterface

// File: rtl/calc_multiport_engine.sv
// Multi-port calculator engine.
//
// NUM_PORTS independent request channels share one registered ALU through a
// round-robin arbiter. Each channel sends a command with operand 1, then
// operand 2 on the following cycle, and later receives a one-cycle response
// code with result data.
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    calc_multiport_engine_if.slave (cmd_in, data_in, out_resp, out_data, busy)
//
// Commands: 0 idle, 1 add, 2 sub (op1 - op2), 5 shl, 6 shr (logical), others invalid.
// Responses: 0 none, 1 success, 2 overflow/underflow, 3 invalid command.
//
// Timeline for an uncontended request whose command is taken at edge k:
//   k    command and op1 captured            (Idle  -> Op2)
//   k+1  op2 captured                        (Op2   -> Ready)
//   k+2  granted, operands enter ALU stage   (Ready -> Exec)
//   k+3  ALU result into output registers    (Exec  -> Resp)
//   k+4  response cycle ends; a new command may be taken on this same edge
// The grant edge and the result edge are one apart because the shared ALU has
// its own input register stage, so one grant per cycle still yields one
// result per cycle under contention.
module calc_multiport_engine #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned SHAMT_W   = $clog2(WIDTH)
) (
  input logic                    clk,
  input logic                    reset,
  calc_multiport_engine_if.slave bus
);

  localparam int unsigned PtrW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [3:0] CmdIdle = 4'd0;
  localparam logic [3:0] CmdAdd  = 4'd1;
  localparam logic [3:0] CmdSub  = 4'd2;
  localparam logic [3:0] CmdShl  = 4'd5;
  localparam logic [3:0] CmdShr  = 4'd6;

  localparam logic [1:0] RespNone    = 2'd0;
  localparam logic [1:0] RespOk      = 2'd1;
  localparam logic [1:0] RespRange   = 2'd2;
  localparam logic [1:0] RespInvalid = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StOp2,
    StReady,
    StExec,
    StResp
  } state_e;

  // Per-port view of the flat input buses.
  logic [3:0]       port_cmd  [NUM_PORTS];
  logic [WIDTH-1:0] port_data [NUM_PORTS];

  // Per-port request state.
  state_e           state_q [NUM_PORTS];
  state_e           state_d [NUM_PORTS];
  logic [3:0]       cmd_q   [NUM_PORTS];
  logic [3:0]       cmd_d   [NUM_PORTS];
  logic [WIDTH-1:0] op1_q   [NUM_PORTS];
  logic [WIDTH-1:0] op1_d   [NUM_PORTS];
  logic [WIDTH-1:0] op2_q   [NUM_PORTS];
  logic [WIDTH-1:0] op2_d   [NUM_PORTS];

  // Arbiter.
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic            grant_valid;
  logic [PtrW-1:0] grant_idx;
  logic [PtrW:0]   cand;

  // Shared ALU input stage.
  logic            alu_valid_q, alu_valid_d;
  logic [PtrW-1:0] alu_port_q, alu_port_d;
  logic [3:0]      alu_cmd_q, alu_cmd_d;
  logic [WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [WIDTH-1:0] alu_op2_q, alu_op2_d;

  // ALU combinational result.
  logic [WIDTH:0]   alu_sum;
  logic [1:0]       alu_resp;
  logic [WIDTH-1:0] alu_result;

  // Per-port output registers.
  logic [1:0]       out_resp_q [NUM_PORTS];
  logic [1:0]       out_resp_d [NUM_PORTS];
  logic [WIDTH-1:0] out_data_q [NUM_PORTS];
  logic [WIDTH-1:0] out_data_d [NUM_PORTS];

  // Flattened outputs.
  logic [NUM_PORTS*2-1:0]     resp_flat;
  logic [NUM_PORTS*WIDTH-1:0] data_flat;
  logic [NUM_PORTS-1:0]       busy_flat;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_cmd[p]  = bus.cmd_in[4*p +: 4];
      port_data[p] = bus.data_in[WIDTH*p +: WIDTH];
    end
  end

  // Round-robin search: start at rr_ptr_q and take the first Ready port,
  // wrapping past the top. rr_ptr then moves just beyond the winner, so a
  // waiting port sees at most NUM_PORTS-1 grants before its own.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
      if (cand >= (PtrW+1)'(NUM_PORTS)) begin
        cand = cand - (PtrW+1)'(NUM_PORTS);
      end
      if (!grant_valid && (state_q[cand[PtrW-1:0]] == StReady)) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      if (grant_idx == PtrW'(NUM_PORTS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + PtrW'(1);
      end
    end
  end

  // Per-port next state. Commands are only taken in Idle or in the last
  // (Resp) cycle of the previous request; anywhere else they are dropped.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      cmd_d[p]   = cmd_q[p];
      op1_d[p]   = op1_q[p];
      op2_d[p]   = op2_q[p];
      unique case (state_q[p])
        StIdle, StResp: begin
          state_d[p] = StIdle;
          if (port_cmd[p] != CmdIdle) begin
            state_d[p] = StOp2;
            cmd_d[p]   = port_cmd[p];
            op1_d[p]   = port_data[p];
          end
        end
        StOp2: begin
          op2_d[p]   = port_data[p];
          state_d[p] = StReady;
        end
        StReady: begin
          if (grant_valid && (grant_idx == PtrW'(p))) begin
            state_d[p] = StExec;
          end
        end
        StExec: begin
          // The ALU stage holds this port's operands; result lands next edge.
          state_d[p] = StResp;
        end
        default: begin
          state_d[p] = StIdle;
        end
      endcase
    end
  end

  // Load the ALU stage from the granted port.
  always_comb begin
    alu_valid_d = grant_valid;
    alu_port_d  = grant_idx;
    alu_cmd_d   = cmd_q[grant_idx];
    alu_op1_d   = op1_q[grant_idx];
    alu_op2_d   = op2_q[grant_idx];
  end

  assign alu_sum = {1'b0, alu_op1_q} + {1'b0, alu_op2_q};

  // Error codes always come with zero data.
  always_comb begin
    alu_resp   = RespInvalid;
    alu_result = '0;
    case (alu_cmd_q)
      CmdAdd: begin
        if (alu_sum[WIDTH]) begin
          alu_resp = RespRange;
        end else begin
          alu_resp   = RespOk;
          alu_result = alu_sum[WIDTH-1:0];
        end
      end
      CmdSub: begin
        if (alu_op2_q > alu_op1_q) begin
          alu_resp = RespRange;
        end else begin
          alu_resp   = RespOk;
          alu_result = alu_op1_q - alu_op2_q;
        end
      end
      CmdShl: begin
        alu_resp   = RespOk;
        alu_result = alu_op1_q << alu_op2_q[SHAMT_W-1:0];
      end
      CmdShr: begin
        alu_resp   = RespOk;
        alu_result = alu_op1_q >> alu_op2_q[SHAMT_W-1:0];
      end
      default: begin
        alu_resp   = RespInvalid;
        alu_result = '0;
      end
    endcase
  end

  // Output registers default to zero each cycle, so a response is visible
  // for exactly the one cycle after the ALU stage retires it.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_resp_d[p] = RespNone;
      out_data_d[p] = '0;
      if (alu_valid_q && (alu_port_q == PtrW'(p))) begin
        out_resp_d[p] = alu_resp;
        out_data_d[p] = alu_result;
      end
    end
  end

  // Control state, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p]    <= StIdle;
        out_resp_q[p] <= RespNone;
        out_data_q[p] <= '0;
      end
      rr_ptr_q    <= '0;
      alu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_resp_q  <= out_resp_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      alu_valid_q <= alu_valid_d;
    end
  end

  // Operand/command payload; only meaningful while the owning state says so.
  always_ff @(posedge clk) begin
    cmd_q      <= cmd_d;
    op1_q      <= op1_d;
    op2_q      <= op2_d;
    alu_port_q <= alu_port_d;
    alu_cmd_q  <= alu_cmd_d;
    alu_op1_q  <= alu_op1_d;
    alu_op2_q  <= alu_op2_d;
  end

  always_comb begin
    resp_flat = '0;
    data_flat = '0;
    busy_flat = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_flat[2*p +: 2]         = out_resp_q[p];
      data_flat[WIDTH*p +: WIDTH] = out_data_q[p];
      busy_flat[p]                = (state_q[p] != StIdle);
    end
  end

  assign bus.out_resp = resp_flat;
  assign bus.out_data = data_flat;
  assign bus.busy     = busy_flat;

endmodule
